// File: rtl/joybus_device.sv
// Joybus controller-side command decoder and response streamer.
// Build option: define JOYBUS_ORIGINS_RAM_EN to fetch origins from memory instead of the fixed table.
module joybus_device #(
  parameter logic [23:0] CONTROLLER_ID    = 24'h090000,
  parameter int          ADDR_WIDTH       = 4,
  parameter int          STATE_BYTES      = 8,
  parameter int          ORIGIN_BASE      = 8,
  parameter int          ORIGIN_BYTES     = 10,
  parameter int          TURNAROUND_TICKS = 2,
  parameter int          TIMEOUT_CYCLES   = 4095
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  tx_tick_i,
  input  logic                  rx_start_i,
  input  logic                  rx_stop_i,
  input  logic                  rx_error_i,
  input  logic                  rx_strobe_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  tx_busy_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_strobe_o,
  output logic                  tx_stopbit_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_request_o,
  input  logic [7:0]            mem_data_i,
  input  logic                  mem_ack_i,
  output logic                  rumble_o,
  output logic                  brake_o,
  output logic                  recal_o,
  output logic                  cmd_error_o
);

  localparam int MAX_A   = (STATE_BYTES > 3) ? STATE_BYTES : 3;
  localparam int MAX_LEN = (ORIGIN_BYTES > MAX_A) ? ORIGIN_BYTES : MAX_A;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int TICK_W  = $clog2(TURNAROUND_TICKS + 2);
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);

`ifdef JOYBUS_ORIGINS_RAM_EN
  localparam bit ORIGINS_FROM_RAM = 1'b1;
`else
  localparam bit ORIGINS_FROM_RAM = 1'b0;
`endif

  // Element 0 is the first byte sent.
  localparam logic [9:0][7:0] ORIGIN_TABLE = {8'h02, 8'h02, 8'h00, 8'h00, 8'h80,
                                              8'h80, 8'h80, 8'h80, 8'h80, 8'h00};

  typedef enum logic [3:0] {
    S_IDLE, S_CMD0, S_POLL1, S_POLL2, S_FINISH,
    S_TURN, S_NEXT, S_FETCH, S_SEND, S_DEAD, S_STOP
  } state_e;

  typedef enum logic [1:0] {RSP_ID, RSP_POLL, RSP_ORIGINS, RSP_RECAL} rsp_e;

  state_e                state_q, state_d;
  rsp_e                  rsp_q, rsp_d;
  logic [7:0]            flags_q, flags_d;
  logic [7:0]            data_q, data_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic                  ack_prev_q;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_strobe_q, tx_strobe_d;
  logic                  tx_stopbit_q, tx_stopbit_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_req_q, mem_req_d;
  logic                  rumble_q, rumble_d;
  logic                  brake_q, brake_d;
  logic                  recal_q, recal_d;
  logic                  cmd_error_q, cmd_error_d;

  logic                  ack_rise;
  logic                  wd_expired;
  logic                  rx_abort;
  logic                  need_mem;
  logic [ADDR_WIDTH-1:0] count_addr;
  logic [ADDR_WIDTH-1:0] origin_addr;
  logic [CNT_W-1:0]      rsp_len;
  logic [7:0]            id_byte;
  logic [7:0]            table_byte;
  logic [7:0]            const_byte;

  assign ack_rise    = mem_ack_i & ~ack_prev_q;
  assign wd_expired  = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign rx_abort    = rx_error_i | rx_start_i | rx_stop_i;
  assign need_mem    = (rsp_q == RSP_POLL) | ORIGINS_FROM_RAM;
  assign count_addr  = ADDR_WIDTH'(count_q);
  assign origin_addr = ADDR_WIDTH'(ORIGIN_BASE) + count_addr;
  assign const_byte  = (rsp_q == RSP_ID) ? id_byte : table_byte;

  always_comb begin
    unique case (rsp_q)
      RSP_ID:   rsp_len = CNT_W'(3);
      RSP_POLL: rsp_len = CNT_W'(STATE_BYTES);
      default:  rsp_len = CNT_W'(ORIGIN_BYTES);
    endcase
  end

  always_comb begin
    id_byte = CONTROLLER_ID[7:0];
    if (count_q == CNT_W'(0))      id_byte = CONTROLLER_ID[23:16];
    else if (count_q == CNT_W'(1)) id_byte = CONTROLLER_ID[15:8];
  end

  // Indices past the end of the table send 0x00.
  always_comb begin
    table_byte = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (int'(count_q) == i) table_byte = ORIGIN_TABLE[i];
    end
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    rsp_d        = rsp_q;
    flags_d      = flags_q;
    data_d       = data_q;
    count_d      = count_q;
    tick_d       = tick_q;
    wdog_d       = '0;
    tx_data_d    = tx_data_q;
    tx_strobe_d  = 1'b0;
    tx_stopbit_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = mem_req_q;
    rumble_d     = rumble_q;
    brake_d      = brake_q;
    recal_d      = 1'b0;
    cmd_error_d  = 1'b0;

    unique case (state_q)
      S_IDLE: if (rx_start_i) state_d = S_CMD0;

      S_CMD0: begin
        if (rx_abort) state_d = S_IDLE;
        else if (rx_strobe_i) begin
          unique case (rx_data_i)
            8'h00, 8'hFF: begin rsp_d = RSP_ID;      state_d = S_FINISH; end
            8'h40:        state_d = S_POLL1;
            8'h41:        begin rsp_d = RSP_ORIGINS; state_d = S_FINISH; end
            8'h42:        begin rsp_d = RSP_RECAL;   state_d = S_FINISH; end
            default:      state_d = S_IDLE;
          endcase
        end
      end

      S_POLL1: begin
        if (rx_abort) state_d = S_IDLE;
        else if (rx_strobe_i) state_d = (rx_data_i == 8'h03) ? S_POLL2 : S_IDLE;
      end

      S_POLL2: begin
        if (rx_abort) state_d = S_IDLE;
        else if (rx_strobe_i) begin
          flags_d = rx_data_i;
          rsp_d   = RSP_POLL;
          state_d = S_FINISH;
        end
      end

      // Any byte after the command is complete makes the request malformed.
      S_FINISH: begin
        if (rx_error_i || rx_start_i || rx_strobe_i) state_d = S_IDLE;
        else if (rx_stop_i) begin
          if (rsp_q == RSP_POLL) begin
            rumble_d = flags_q[0];
            brake_d  = flags_q[1];
          end
          recal_d = (rsp_q == RSP_RECAL);
          count_d = '0;
          tick_d  = '0;
          state_d = S_TURN;
        end
      end

      S_TURN: begin
        if (tick_q == TICK_W'(TURNAROUND_TICKS)) state_d = S_NEXT;
        else if (tx_tick_i) tick_d = tick_q + TICK_W'(1);
      end

      S_NEXT: begin
        if (count_q == rsp_len) state_d = S_STOP;
        else if (need_mem) begin
          mem_req_d  = 1'b1;
          mem_addr_d = (rsp_q == RSP_POLL) ? count_addr : origin_addr;
          state_d    = S_FETCH;
        end else begin
          data_d  = const_byte;
          state_d = S_SEND;
        end
      end

      S_FETCH: begin
        wdog_d = wdog_q + WD_W'(1);
        if (ack_rise) begin
          data_d    = mem_data_i;
          mem_req_d = 1'b0;
          state_d   = S_SEND;
        end else if (wd_expired) begin
          mem_req_d   = 1'b0;
          cmd_error_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      S_SEND: begin
        wdog_d = wdog_q + WD_W'(1);
        if (!tx_busy_i) begin
          tx_strobe_d = 1'b1;
          tx_data_d   = data_q;
          state_d     = S_DEAD;
        end else if (wd_expired) begin
          cmd_error_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      // Gives the transmitter a cycle to raise tx_busy before the next send.
      S_DEAD: begin
        count_d = count_q + CNT_W'(1);
        state_d = S_NEXT;
      end

      S_STOP: begin
        wdog_d = wdog_q + WD_W'(1);
        if (!tx_busy_i) begin
          tx_strobe_d  = 1'b1;
          tx_stopbit_d = 1'b1;
          state_d      = S_IDLE;
        end else if (wd_expired) begin
          cmd_error_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      rsp_q        <= RSP_ID;
      flags_q      <= '0;
      data_q       <= '0;
      count_q      <= '0;
      tick_q       <= '0;
      wdog_q       <= '0;
      ack_prev_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_strobe_q  <= 1'b0;
      tx_stopbit_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
      rumble_q     <= 1'b0;
      brake_q      <= 1'b0;
      recal_q      <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_q        <= rsp_d;
      flags_q      <= flags_d;
      data_q       <= data_d;
      count_q      <= count_d;
      tick_q       <= tick_d;
      wdog_q       <= wdog_d;
      ack_prev_q   <= mem_ack_i;
      tx_data_q    <= tx_data_d;
      tx_strobe_q  <= tx_strobe_d;
      tx_stopbit_q <= tx_stopbit_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      rumble_q     <= rumble_d;
      brake_q      <= brake_d;
      recal_q      <= recal_d;
      cmd_error_q  <= cmd_error_d;
    end
  end

  assign tx_data_o     = tx_data_q;
  assign tx_strobe_o   = tx_strobe_q;
  assign tx_stopbit_o  = tx_stopbit_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_request_o = mem_req_q;
  assign rumble_o      = rumble_q;
  assign brake_o       = brake_q;
  assign recal_o       = recal_q;
  assign cmd_error_o   = cmd_error_q;

endmodule

// File: tb/tb_joybus_device.sv
// Self-checking bench for joybus_device: command table, random commands, watchdog and reset abort.
module tb_joybus_device;

  localparam int TIMEOUT = 4095;
  localparam int TURN    = 2;
  localparam int K_NONE = 0, K_ID = 1, K_POLL = 2, K_ORIG = 3, K_RECAL = 4;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       tx_tick = 1'b0, rx_start = 1'b0, rx_stop = 1'b0, rx_error = 1'b0, rx_strobe = 1'b0;
  logic [7:0] rx_data = 8'h00, mem_data = 8'h00;
  logic       tx_busy = 1'b0, mem_ack = 1'b0;
  logic [7:0] tx_data;
  logic       tx_strobe, tx_stopbit, mem_request, rumble, brake, recal, cmd_error;
  logic [3:0] mem_addr;

  joybus_device dut (
    .clk_i(clk), .reset_ni(reset_n), .tx_tick_i(tx_tick),
    .rx_start_i(rx_start), .rx_stop_i(rx_stop), .rx_error_i(rx_error),
    .rx_strobe_i(rx_strobe), .rx_data_i(rx_data), .tx_busy_i(tx_busy),
    .tx_data_o(tx_data), .tx_strobe_o(tx_strobe), .tx_stopbit_o(tx_stopbit),
    .mem_addr_o(mem_addr), .mem_request_o(mem_request), .mem_data_i(mem_data),
    .mem_ack_i(mem_ack), .rumble_o(rumble), .brake_o(brake), .recal_o(recal),
    .cmd_error_o(cmd_error)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- environment models ----------------
  logic [7:0] mem [16];
  bit         mem_stall = 1'b0;
  int         mem_wait = -1, busy_cnt = 0, tick_div = 0;

  always @(negedge clk) begin
    tick_div = (tick_div == 4) ? 0 : tick_div + 1;
    tx_tick  = (tick_div == 0);
  end

  always @(negedge clk) begin
    if (tx_strobe) begin
      tx_busy  = 1'b1;
      busy_cnt = $urandom_range(3, 8);
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!mem_request) begin
      mem_ack  = 1'b0;
      mem_wait = -1;
    end else if (!mem_ack && !mem_stall) begin
      if (mem_wait < 0) mem_wait = $urandom_range(0, 3);
      else if (mem_wait == 0) begin
        mem_data = mem[mem_addr];
        mem_ack  = 1'b1;
      end else mem_wait--;
    end
  end

  // ---------------- monitor ----------------
  logic [8:0] txq[$];
  int         tick_cyc[$];
  int         cyc = 0, recal_n = 0, err_n = 0, err_cyc = 0, req_cyc = 0, stop_cyc = -1, first_cyc = -1;
  bit         req_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (tx_strobe) begin
      if (txq.size() == 0) first_cyc = cyc;
      txq.push_back({tx_stopbit, tx_data});
    end
    if (rx_stop) stop_cyc = cyc;
    if (tx_tick) tick_cyc.push_back(cyc);
    if (recal) recal_n++;
    if (cmd_error) begin err_n++; err_cyc = cyc; end
    if (mem_request && !req_prev) req_cyc = cyc;
    req_prev = mem_request;
  end

  task automatic clear_log();
    txq.delete(); tick_cyc.delete();
    recal_n = 0; err_n = 0; stop_cyc = -1; first_cyc = -1;
  endtask

  function automatic int stop_count();
    int n = 0;
    foreach (txq[i]) if (txq[i][8]) n++;
    return n;
  endfunction

  function automatic int data_count();
    int n = 0;
    foreach (txq[i]) if (!txq[i][8]) n++;
    return n;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  bit         exp_rum = 1'b0, exp_brk = 1'b0;

  function automatic int classify(int n, logic [7:0] b0, logic [7:0] b1, int mode);
    if (mode != 0) return K_NONE;
    if (n == 1 && (b0 == 8'h00 || b0 == 8'hFF)) return K_ID;
    if (n == 1 && b0 == 8'h41) return K_ORIG;
    if (n == 1 && b0 == 8'h42) return K_RECAL;
    if (n == 3 && b0 == 8'h40 && b1 == 8'h03) return K_POLL;
    return K_NONE;
  endfunction

  function automatic void model_response(int kind);
    logic [23:0] id = 24'h090000;
`ifndef JOYBUS_ORIGINS_RAM_EN
    logic [7:0] tbl [10];
    tbl = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h02, 8'h02};
`endif
    exp_q.delete();
    case (kind)
      K_ID: begin exp_q.push_back(id[23:16]); exp_q.push_back(id[15:8]); exp_q.push_back(id[7:0]); end
      K_POLL: for (int i = 0; i < 8; i++) exp_q.push_back(mem[i]);
      K_ORIG, K_RECAL: for (int i = 0; i < 10; i++) begin
`ifdef JOYBUS_ORIGINS_RAM_EN
        exp_q.push_back(mem[(8 + i) % 16]);
`else
        exp_q.push_back(tbl[i]);
`endif
      end
      default: ;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  task automatic pulse_byte(input logic [7:0] b);
    rx_data = b; rx_strobe = 1'b1;
    @(negedge clk) rx_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // mode 0: clean, 1: extra byte before stop, 2: rx_error after first byte
  task automatic send_cmd(input int n, input logic [7:0] b0, b1, b2, input int mode);
    logic [7:0] bytes [3];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    @(negedge clk) rx_start = 1'b1;
    @(negedge clk) rx_start = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      pulse_byte(bytes[i]);
      if (mode == 2 && i == 0) begin
        rx_error = 1'b1;
        @(negedge clk) rx_error = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
    if (mode == 1) pulse_byte(8'h00);
    rx_stop = 1'b1;
    @(negedge clk) rx_stop = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input int n, input logic [7:0] b0, b1, b2,
                         input int mode, input int kind, input bit rum, input bit brk);
    logic [7:0] got[$];
    int         nt;
    clear_log();
    send_cmd(n, b0, b1, b2, mode);
    model_response(kind);
    if (kind != K_NONE) begin
      for (int k = 0; k < 3000 && stop_count() == 0; k++) @(negedge clk);
      check({tag, " done"}, 32'(stop_count() != 0), 32'd1);
    end else repeat (80) @(negedge clk);
    foreach (txq[i]) if (!txq[i][8]) got.push_back(txq[i][7:0]);
    check({tag, " len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    check({tag, " stopbits"}, 32'(stop_count()), (kind != K_NONE) ? 32'd1 : 32'd0);
    check({tag, " rumble"}, 32'(rumble), 32'(rum));
    check({tag, " brake"}, 32'(brake), 32'(brk));
    check({tag, " recal"}, 32'(recal_n), (kind == K_RECAL) ? 32'd1 : 32'd0);
    check({tag, " cmd_error"}, 32'(err_n), 32'd0);
    if (kind == K_ID) begin
      nt = 0;
      foreach (tick_cyc[i]) if (tick_cyc[i] > stop_cyc && tick_cyc[i] < first_cyc) nt++;
      check({tag, " turnaround"}, 32'(nt), 32'(TURN));
    end
    repeat (20) @(negedge clk);
  endtask

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2;
    int         mode;
    int         kind;
    bit         rum, brk;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    vecs[0]  = '{1, 8'h00, 8'h00, 8'h00, 0, K_ID,    1'b0, 1'b0};
    vecs[1]  = '{1, 8'hFF, 8'h00, 8'h00, 0, K_ID,    1'b0, 1'b0};
    vecs[2]  = '{3, 8'h40, 8'h03, 8'h03, 0, K_POLL,  1'b1, 1'b1};
    vecs[3]  = '{3, 8'h40, 8'h03, 8'h00, 0, K_POLL,  1'b0, 1'b0};
    vecs[4]  = '{3, 8'h40, 8'h03, 8'h01, 0, K_POLL,  1'b1, 1'b0};
    vecs[5]  = '{1, 8'h42, 8'h00, 8'h00, 0, K_RECAL, 1'b1, 1'b0};
    vecs[6]  = '{1, 8'h41, 8'h00, 8'h00, 0, K_ORIG,  1'b1, 1'b0};
    vecs[7]  = '{3, 8'h40, 8'h04, 8'h02, 0, K_NONE,  1'b1, 1'b0};
    vecs[8]  = '{1, 8'h00, 8'h00, 8'h00, 1, K_NONE,  1'b1, 1'b0};
    vecs[9]  = '{3, 8'h40, 8'h03, 8'h02, 2, K_NONE,  1'b1, 1'b0};
    vecs[10] = '{1, 8'h55, 8'h00, 8'h00, 0, K_NONE,  1'b1, 1'b0};

    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * (i + 1));
    for (int i = 8; i < 16; i++) mem[i] = 8'(8'hA0 + (i - 8));

    repeat (3) @(negedge clk);
    #1;
    check("reset outputs", 32'({tx_data, tx_strobe, tx_stopbit, mem_addr, mem_request,
                                rumble, brake, recal, cmd_error}), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vecs[i])
      run_cmd($sformatf("vec%0d", i), vecs[i].n, vecs[i].b0, vecs[i].b1, vecs[i].b2,
              vecs[i].mode, vecs[i].kind, vecs[i].rum, vecs[i].brk);
    exp_rum = 1'b1; exp_brk = 1'b0;

    // Watchdog: memory never acknowledges during a poll.
    mem_stall = 1'b1;
    clear_log();
    send_cmd(3, 8'h40, 8'h03, 8'h01, 0);
    for (int k = 0; k < TIMEOUT + 1000 && err_n == 0; k++) @(negedge clk);
    check("wdog fired", 32'(err_n), 32'd1);
    check("wdog delay", 32'(err_cyc - req_cyc), 32'(TIMEOUT));
    @(negedge clk);
    check("wdog mem_request", 32'(mem_request), 32'd0);
    check("wdog strobes", 32'(txq.size()), 32'd0);
    check("wdog rumble", 32'(rumble), 32'd1);
    mem_stall = 1'b0;
    repeat (10) @(negedge clk);
    run_cmd("post-wdog id", 1, 8'h00, 8'h00, 8'h00, 0, K_ID, exp_rum, exp_brk);

    // Reset abort during the fourth poll byte fetch.
    clear_log();
    send_cmd(3, 8'h40, 8'h03, 8'h03, 0);
    for (int k = 0; k < 2000 && data_count() < 3; k++) @(negedge clk);
    check("abort reached byte3", 32'(data_count() >= 3), 32'd1);
    for (int k = 0; k < 200 && !mem_request; k++) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort outputs", 32'({tx_data, tx_strobe, tx_stopbit, mem_addr, mem_request,
                                rumble, brake, recal, cmd_error}), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    exp_rum = 1'b0; exp_brk = 1'b0;
    run_cmd("post-reset poll", 3, 8'h40, 8'h03, 8'h00, 0, K_POLL, exp_rum, exp_brk);

    // Randomised commands against the reference model.
    for (int it = 0; it < 25; it++) begin
      int         sel, n, mode, kind;
      logic [7:0] b0, b1, b2;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      sel = $urandom_range(0, 6);
      n = 1; b1 = 8'h00; b2 = 8'h00;
      case (sel)
        0: b0 = 8'h00;
        1: b0 = 8'hFF;
        2: begin n = 3; b0 = 8'h40; b1 = 8'h03; b2 = 8'($urandom); end
        3: b0 = 8'h41;
        4: b0 = 8'h42;
        5: begin n = 3; b0 = 8'h40; b1 = 8'($urandom_range(4, 255)); b2 = 8'($urandom); end
        default: b0 = 8'($urandom_range(1, 8'h3F));
      endcase
      mode = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      kind = classify(n, b0, b1, mode);
      if (kind == K_POLL) begin exp_rum = b2[0]; exp_brk = b2[1]; end
      run_cmd($sformatf("rnd%0d", it), n, b0, b1, b2, mode, kind, exp_rum, exp_brk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
